mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one pipelined, fixed-latency memory between two requesters: the instruction-fetch port (I, port 0) and the load/store port (D, port 1).
- Does round-robin grant with valid/ready handshakes and a per-port outstanding-request limit.
- Tracks in-flight requests with a tag pipeline and routes each read response back to its owner.
- Provides a drain handshake so the core can quiesce memory traffic before halt.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
LATENCY, 4, cycles from mem_* issue to mem_rdata valid (matches the 4-stage memory delay line)
MAX_OUT, 4, max outstanding requests per port (1..LATENCY+1)

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  reset, synchronous, active-high (1 = reset)
i_req_valid  in  1  instruction request
i_req_addr  in  ADDR_W  instruction address
i_req_ready  out  1  instruction request accepted this cycle
i_resp_valid  out  1  instruction data valid
i_resp_data  out  DATA_W  instruction word
d_req_valid  in  1  data request
d_req_addr  in  ADDR_W  data address
d_req_we  in  1  1 = store, 0 = load
d_req_wdata  in  DATA_W  store data
d_req_ready  out  1  data request accepted this cycle
d_resp_valid  out  1  load data valid, or store acknowledge
d_resp_data  out  DATA_W  load data (0 for a store ack)
mem_addr  out  ADDR_W  registered memory address
mem_we  out  1  registered write enable
mem_wdata  out  DATA_W  registered write data
mem_rdata  in  DATA_W  memory read data, LATENCY cycles after issue
drain_req  in  1  stop issuing and empty the pipeline
drained  out  1  pipeline empty and issue stopped

Behaviour:
- Reset values:
  - All outputs 0, counters 0, tag pipeline empty, FSM = RUN.
  - last_grant = 1, so I wins the first tie.
  - Reset mid-operation discards all in-flight responses; no resp_valid pulses after reset.
- Eligibility: port p is eligible when p_req_valid=1, FSM=RUN and out_cnt[p] < MAX_OUT. The count is not bypassed by a same-cycle response.
- Grant (combinational, same cycle):
  - Only one port is eligible: grant it.
  - Both are eligible: grant the port != last_grant.
  - p_req_ready = grant[p]; at most one ready per cycle.
  - last_grant updates only on a grant.
- Issue: on grant, the next rising edge loads mem_addr/mem_we/mem_wdata from the winner. With no grant, mem_we is loaded 0 and addr/wdata hold. An I request always issues mem_we=0.
- Tag pipeline:
  - LATENCY+1 stages, each carrying {valid, port, is_write}.
  - Stage 0 is loaded at the same edge as the mem_* registers.
  - Output stage valid yields p_resp_valid for exactly one cycle, with p_resp_data = mem_rdata (or 0 if is_write).
  - Accept-to-response latency is exactly LATENCY+1 cycles.
  - Back-to-back requests return back-to-back responses, in order.
- out_cnt[p] (width clog2(MAX_OUT+1)): +1 on grant, -1 on response. Both in the same cycle leaves it unchanged. It never wraps; exceeding MAX_OUT or going below 0 is an assertion failure.
- Drain FSM:
  - RUN: drain_req=1 -> DRAIN, and no grant that cycle.
  - DRAIN: -> DRAINED when both out_cnt=0 and the pipeline is empty.
  - DRAINED: drained=1; drain_req=0 -> RUN, with grants allowed from the next cycle.
  - If drain_req drops while in DRAIN, stay in DRAIN until empty, then go via DRAINED.
- Requests must hold valid/addr/wdata stable until ready (requester obligation; asserted in verification).

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {RUN, DRAIN, DRAINED}
  - PORT_I = 0, PORT_D = 1
  - tag struct {valid, port, is_write}
- Sub-module mem_tag_pipe: a parameterised LATENCY+1-stage shift register of tag structs with synchronous active-high reset. It exposes the output stage and an any_valid flag.

Test Plan:
- Single load: D load at 0x100 with memory word 0xDEADBEEF; d_req_ready in the same cycle, d_resp_valid exactly 5 cycles later with data 0xDEADBEEF, and i_resp_valid stays 0.
- Contention: I and D held valid for 6 cycles -> grants alternate I,D,I,D,I,D, and responses alternate the same way 5 cycles after each grant.
- Outstanding limit: MAX_OUT=2, I valid continuously, memory latency 4 -> i_req_ready at cycles 0 and 1, then 0 until the first response at cycle 5, then 1 in that same cycle's successor.
- Store: D store 0x1234 to 0x40 -> mem_we=1, mem_addr=0x40, mem_wdata=0x1234 one cycle after accept; d_resp_valid with data 0 five cycles after accept.
- Drain: 3 requests in flight, drain_req=1 -> no further readies, drained=1 the cycle after the last response; drain_req=0 -> next pending request granted the following cycle.
- Reset mid-flight: rst_b=1 with 2 loads outstanding -> all outputs 0 next cycle, no resp_valid afterwards, I wins the first post-reset tie.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: drain FSM states, port ids
// and the in-flight tag carried alongside each memory access.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      DRAIN   = 2'd1,
      DRAINED = 2'd2
   } state_e;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   typedef struct packed {
      logic valid;
      logic port;
      logic is_write;
   } tag_t;

endpackage

// File: rtl/mem_tag_pipe.sv
// Fixed-depth shift register of request tags; the last stage lines up with
// the memory read data of the access it describes.
module mem_tag_pipe
   import mem_arb_pkg::*;
#(
   parameter int STAGES = 5
) (
   input  logic clk_i,
   input  logic rst_i,
   input  tag_t tag_i,
   output tag_t tag_o,
   output logic any_valid_o
);

   tag_t [STAGES-1:0] stage_q;
   tag_t [STAGES-1:0] stage_d;

   always_comb begin
      stage_d = {stage_q[STAGES-2:0], tag_i};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   always_comb begin
      any_valid_o = 1'b0;
      for (int s = 0; s < STAGES; s++) begin
         any_valid_o = any_valid_o | stage_q[s].valid;
      end
   end

   assign tag_o = stage_q[STAGES-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between the fetch (I)
// and load/store (D) ports, with per-port outstanding limits and a drain FSM.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 4,
   parameter int MAX_OUT = 4
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              i_req_valid,
   input  logic [ADDR_W-1:0] i_req_addr,
   output logic              i_req_ready,
   output logic              i_resp_valid,
   output logic [DATA_W-1:0] i_resp_data,
   input  logic              d_req_valid,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic              d_req_we,
   input  logic [DATA_W-1:0] d_req_wdata,
   output logic              d_req_ready,
   output logic              d_resp_valid,
   output logic [DATA_W-1:0] d_resp_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              drain_req,
   output logic              drained
);

   localparam int               CNT_W   = $clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

   state_e                 state_q, state_d;
   logic                   last_grant_q, last_grant_d;
   logic [1:0][CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic                   we_q, we_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   logic [1:0]             elig, grant, resp;
   logic                   issue_ok, drain_done, pipe_any_valid;
   tag_t                   tag_in, tag_out;

   // Issue is blocked in the very cycle drain_req rises, not just after.
   always_comb begin
      elig         = '0;
      issue_ok     = !rst_b && (state_q == RUN) && !drain_req;
      elig[PORT_I] = issue_ok && i_req_valid && (cnt_q[PORT_I] < CNT_MAX);
      elig[PORT_D] = issue_ok && d_req_valid && (cnt_q[PORT_D] < CNT_MAX);
      if (&elig) begin
         grant = last_grant_q ? 2'b01 : 2'b10;
      end else begin
         grant = elig;
      end
      last_grant_d = (|grant) ? grant[PORT_D] : last_grant_q;
   end

   assign i_req_ready = grant[PORT_I];
   assign d_req_ready = grant[PORT_D];

   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      if (grant[PORT_I]) begin
         addr_d = i_req_addr;
      end else if (grant[PORT_D]) begin
         addr_d  = d_req_addr;
         we_d    = d_req_we;
         wdata_d = d_req_wdata;
      end
   end

   always_comb begin
      tag_in          = '0;
      tag_in.valid    = |grant;
      tag_in.port     = grant[PORT_D];
      tag_in.is_write = grant[PORT_D] & d_req_we;
   end

   mem_tag_pipe #(
      .STAGES (LATENCY + 1)
   ) u_tag_pipe (
      .clk_i       (clk),
      .rst_i       (rst_b),
      .tag_i       (tag_in),
      .tag_o       (tag_out),
      .any_valid_o (pipe_any_valid)
   );

   always_comb begin
      resp         = '0;
      resp[PORT_I] = tag_out.valid && (tag_out.port == PORT_I);
      resp[PORT_D] = tag_out.valid && (tag_out.port == PORT_D);
   end

   assign i_resp_valid = resp[PORT_I];
   assign d_resp_valid = resp[PORT_D];
   assign i_resp_data  = resp[PORT_I] ? mem_rdata : '0;
   assign d_resp_data  = (resp[PORT_D] && !tag_out.is_write) ? mem_rdata : '0;

   always_comb begin
      cnt_d = cnt_q;
      for (int p = 0; p < 2; p++) begin
         if (grant[p] && !resp[p]) begin
            cnt_d[p] = cnt_q[p] + CNT_W'(1);
         end else if (!grant[p] && resp[p]) begin
            cnt_d[p] = cnt_q[p] - CNT_W'(1);
         end
      end
   end

   // Judged on post-edge counts so drained rises right after the last response.
   assign drain_done = (cnt_d == '0) && (tag_out.valid || !pipe_any_valid);

   always_ff @(posedge clk) begin
      if (rst_b) begin
         state_q      <= RUN;
         last_grant_q <= PORT_D;
         cnt_q        <= '0;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (drain_req)  state_d = DRAIN;
         DRAIN:   if (drain_done) state_d = DRAINED;
         DRAINED: if (!drain_req) state_d = RUN;
         default:                 state_d = RUN;
      endcase
   end

   always_comb begin
      drained = (state_q == DRAINED);
   end

   assign mem_addr  = addr_q;
   assign mem_we    = we_q;
   assign mem_wdata = wdata_q;

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         for (int p = 0; p < 2; p++) begin
            assert (!(grant[p] && !resp[p] && (cnt_q[p] == CNT_MAX)));
            assert (!(resp[p] && !grant[p] && (cnt_q[p] == '0)));
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run checked against a queue-based
// model of scheduled responses; a second instance exercises MAX_OUT=2.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_b;
   logic        i_req_valid, i_req_ready, i_resp_valid;
   logic [31:0] i_req_addr, i_resp_data;
   logic        d_req_valid, d_req_we, d_req_ready, d_resp_valid;
   logic [31:0] d_req_addr, d_req_wdata, d_resp_data;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, drain_req, drained;

   logic        lim_i_valid, lim_i_ready, lim_i_resp_valid;
   logic [31:0] lim_i_addr, lim_i_resp_data;
   logic        lim_d_ready, lim_d_resp_valid, lim_mem_we, lim_drained;
   logic [31:0] lim_d_resp_data, lim_mem_addr, lim_mem_wdata;

   int n_checks = 0;
   int n_pass   = 0;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
   endfunction

   // Four-stage memory delay line: data appears LATENCY cycles after issue.
   logic [31:0] dl [4];
   always @(posedge clk) begin
      dl[0] <= mem_addr;
      dl[1] <= dl[0];
      dl[2] <= dl[1];
      dl[3] <= dl[2];
   end
   assign mem_rdata = memfn(dl[3]);

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(4), .MAX_OUT(4)) u_dut (
      .clk(clk), .rst_b(rst_b),
      .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
      .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
      .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
      .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
      .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .drain_req(drain_req), .drained(drained)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(4), .MAX_OUT(2)) u_lim (
      .clk(clk), .rst_b(rst_b),
      .i_req_valid(lim_i_valid), .i_req_addr(lim_i_addr), .i_req_ready(lim_i_ready),
      .i_resp_valid(lim_i_resp_valid), .i_resp_data(lim_i_resp_data),
      .d_req_valid(1'b0), .d_req_addr(32'h0), .d_req_we(1'b0),
      .d_req_wdata(32'h0), .d_req_ready(lim_d_ready),
      .d_resp_valid(lim_d_resp_valid), .d_resp_data(lim_d_resp_data),
      .mem_addr(lim_mem_addr), .mem_we(lim_mem_we), .mem_wdata(lim_mem_wdata),
      .mem_rdata(32'hC0DE0001), .drain_req(1'b0), .drained(lim_drained)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
      d_req_we    = 1'b0;
      drain_req   = 1'b0;
      lim_i_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_b = 1'b1;
      i_req_valid = 1'b1; d_req_valid = 1'b1; lim_i_valid = 1'b1;
      i_req_addr = 32'h10; d_req_addr = 32'h20; d_req_wdata = 32'h55;
      tick(); tick(); #4;
      n_checks++;
      if ({i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, drained, mem_we} !== 6'b0)
         $display("FAIL reset_ctrl: got %b want 000000",
                  {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, drained, mem_we});
      else n_pass++;
      n_checks++;
      if ({mem_addr, mem_wdata, i_resp_data, d_resp_data} !== 128'h0)
         $display("FAIL reset_data: addr %h wdata %h idata %h ddata %h want 0",
                  mem_addr, mem_wdata, i_resp_data, d_resp_data);
      else n_pass++;
      n_checks++;
      if (lim_i_ready !== 1'b0) $display("FAIL reset_lim_ready: got %b want 0", lim_i_ready);
      else n_pass++;
      idle();
      rst_b = 1'b0;
      tick();
   endtask

   task automatic test_single_load();
      d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h100;
      for (int c = 0; c < 8; c++) begin
         #4;
         if (c == 0) begin
            n_checks++;
            if (d_req_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", d_req_ready);
            else n_pass++;
         end
         n_checks++;
         if (d_resp_valid !== (c == 5) || i_resp_valid !== 1'b0)
            $display("FAIL single_resp c%0d: d_valid %b i_valid %b want %b 0",
                     c, d_resp_valid, i_resp_valid, (c == 5));
         else n_pass++;
         if (c == 5) begin
            n_checks++;
            if (d_resp_data !== 32'hDEADBEEF)
               $display("FAIL single_data: got %h want deadbeef", d_resp_data);
            else n_pass++;
         end
         tick();
         if (c == 0) idle();
      end
   endtask

   task automatic test_contention();
      int in = 0, dn = 0;
      bit exp_ri, exp_rd, exp_vi, exp_vd;
      for (int c = 0; c < 12; c++) begin
         i_req_valid = (c < 6); d_req_valid = (c < 6); d_req_we = 1'b0;
         i_req_addr = 32'h1000 + 32'(in) * 4;
         d_req_addr = 32'h2000 + 32'(dn) * 4;
         #4;
         exp_ri = (c < 6) && (c % 2 == 0);
         exp_rd = (c < 6) && (c % 2 == 1);
         exp_vi = (c >= 5) && (c <= 10) && ((c - 5) % 2 == 0);
         exp_vd = (c >= 5) && (c <= 10) && ((c - 5) % 2 == 1);
         n_checks++;
         if ({i_req_ready, d_req_ready} !== {exp_ri, exp_rd})
            $display("FAIL contend_grant c%0d: got %b%b want %b%b", c, i_req_ready, d_req_ready, exp_ri, exp_rd);
         else n_pass++;
         n_checks++;
         if ({i_resp_valid, d_resp_valid} !== {exp_vi, exp_vd})
            $display("FAIL contend_resp c%0d: got %b%b want %b%b", c, i_resp_valid, d_resp_valid, exp_vi, exp_vd);
         else n_pass++;
         if (exp_vi) begin
            n_checks++;
            if (i_resp_data !== memfn(32'h1000 + 32'((c - 5) / 2) * 4))
               $display("FAIL contend_idata c%0d: got %h want %h", c, i_resp_data, memfn(32'h1000 + 32'((c - 5) / 2) * 4));
            else n_pass++;
         end
         if (exp_vd) begin
            n_checks++;
            if (d_resp_data !== memfn(32'h2000 + 32'((c - 6) / 2) * 4))
               $display("FAIL contend_ddata c%0d: got %h want %h", c, d_resp_data, memfn(32'h2000 + 32'((c - 6) / 2) * 4));
            else n_pass++;
         end
         if (exp_ri) in++;
         if (exp_rd) dn++;
         tick();
      end
      idle();
   endtask

   task automatic test_out_limit();
      logic [11:0] rdy_exp  = 12'h0C3;
      logic [11:0] resp_exp = 12'h860;
      lim_i_valid = 1'b1; lim_i_addr = 32'h500;
      for (int c = 0; c < 12; c++) begin
         #4;
         n_checks++;
         if (lim_i_ready !== rdy_exp[c])
            $display("FAIL limit_ready c%0d: got %b want %b", c, lim_i_ready, rdy_exp[c]);
         else n_pass++;
         n_checks++;
         if (lim_i_resp_valid !== resp_exp[c])
            $display("FAIL limit_resp c%0d: got %b want %b", c, lim_i_resp_valid, resp_exp[c]);
         else n_pass++;
         if (resp_exp[c]) begin
            n_checks++;
            if (lim_i_resp_data !== 32'hC0DE0001)
               $display("FAIL limit_data c%0d: got %h want c0de0001", c, lim_i_resp_data);
            else n_pass++;
         end
         n_checks++;
         if ({lim_mem_we, lim_d_ready, lim_d_resp_valid, lim_drained} !== 4'b0 ||
             lim_mem_wdata !== 32'h0 || lim_d_resp_data !== 32'h0 ||
             (c >= 1 && lim_mem_addr !== 32'h500))
            $display("FAIL limit_side c%0d: we %b drdy %b dvalid %b drained %b wdata %h ddata %h addr %h",
                     c, lim_mem_we, lim_d_ready, lim_d_resp_valid, lim_drained,
                     lim_mem_wdata, lim_d_resp_data, lim_mem_addr);
         else n_pass++;
         tick();
      end
      idle();
      repeat (6) tick();
   endtask

   task automatic test_store();
      d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h40; d_req_wdata = 32'h1234;
      for (int c = 0; c < 7; c++) begin
         #4;
         if (c == 0) begin
            n_checks++;
            if (d_req_ready !== 1'b1) $display("FAIL store_ready: got %b want 1", d_req_ready);
            else n_pass++;
         end
         if (c == 1) begin
            n_checks++;
            if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h1234)
               $display("FAIL store_issue: we %b addr %h wdata %h want 1 40 1234", mem_we, mem_addr, mem_wdata);
            else n_pass++;
         end
         if (c == 2) begin
            n_checks++;
            if (mem_we !== 1'b0) $display("FAIL store_we_drop: got %b want 0", mem_we);
            else n_pass++;
         end
         n_checks++;
         if (d_resp_valid !== (c == 5) || (c == 5 && d_resp_data !== 32'h0))
            $display("FAIL store_ack c%0d: valid %b data %h want %b 0", c, d_resp_valid, d_resp_data, (c == 5));
         else n_pass++;
         tick();
         if (c == 0) idle();
      end
   endtask

   task automatic test_drain();
      bit exp_rd, exp_v, exp_dr;
      logic [31:0] exp_data;
      for (int c = 0; c < 17; c++) begin
         d_req_valid = (c <= 11); d_req_we = 1'b0;
         d_req_addr  = (c <= 2) ? 32'h300 + 32'(c) * 4 : 32'h400;
         drain_req   = (c >= 3) && (c <= 9);
         #4;
         exp_rd = (c <= 2) || (c == 11);
         exp_v  = ((c >= 5) && (c <= 7)) || (c == 16);
         exp_dr = (c >= 8) && (c <= 10);
         exp_data = (c == 16) ? memfn(32'h400) : memfn(32'h300 + 32'(c - 5) * 4);
         n_checks++;
         if (d_req_ready !== exp_rd) $display("FAIL drain_ready c%0d: got %b want %b", c, d_req_ready, exp_rd);
         else n_pass++;
         n_checks++;
         if (d_resp_valid !== exp_v || (exp_v && d_resp_data !== exp_data))
            $display("FAIL drain_resp c%0d: valid %b data %h want %b %h", c, d_resp_valid, d_resp_data, exp_v, exp_data);
         else n_pass++;
         n_checks++;
         if (drained !== exp_dr) $display("FAIL drain_flag c%0d: got %b want %b", c, drained, exp_dr);
         else n_pass++;
         tick();
      end
      idle();
   endtask

   task automatic test_reset_midflight();
      i_req_valid = 1'b1; i_req_addr = 32'h600;
      tick();
      i_req_addr = 32'h604;
      tick();
      idle(); rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      for (int c = 3; c < 10; c++) begin
         #4;
         if (c == 3) begin
            n_checks++;
            if ({i_req_ready, d_req_ready, mem_we, drained} !== 4'b0 ||
                {mem_addr, mem_wdata, i_resp_data, d_resp_data} !== 128'h0)
               $display("FAIL midreset_zero: rdy %b%b we %b drained %b addr %h wdata %h want 0",
                        i_req_ready, d_req_ready, mem_we, drained, mem_addr, mem_wdata);
            else n_pass++;
         end
         n_checks++;
         if ({i_resp_valid, d_resp_valid} !== 2'b00)
            $display("FAIL midreset_resp c%0d: got %b%b want 00", c, i_resp_valid, d_resp_valid);
         else n_pass++;
         tick();
      end
      i_req_valid = 1'b1; d_req_valid = 1'b1; i_req_addr = 32'h700; d_req_addr = 32'h704;
      #4;
      n_checks++;
      if ({i_req_ready, d_req_ready} !== 2'b10)
         $display("FAIL midreset_tie: got %b%b want 10", i_req_ready, d_req_ready);
      else n_pass++;
      tick();
      idle();
      repeat (7) tick();
   endtask

   typedef struct {
      int          due;
      bit          port;
      bit          we;
      logic [31:0] data;
   } pend_t;

   task automatic test_random();
      pend_t q[$];
      bit m_last = 1'b1;
      bit iv = 0, dv = 0, dwe = 0;
      logic [31:0] ia = '0, da = '0, dw = '0;
      bit exp_issue = 0, exp_we = 0, exp_from_d = 0;
      logic [31:0] exp_addr = '0, exp_wdata = '0;
      int ni, nd;
      bit ei, ed, gi, gd, evi, evd;
      logic [31:0] eidata, eddata;
      rst_b = 1'b1; idle();
      tick();
      rst_b = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!iv) begin
            iv = ($urandom_range(0, 99) < 60); ia = $urandom & 32'h0000FFFC;
         end
         if (!dv) begin
            dv = ($urandom_range(0, 99) < 50); da = $urandom & 32'h0000FFFC;
            dwe = ($urandom_range(0, 3) == 0); dw = $urandom;
         end
         i_req_valid = iv; i_req_addr = ia;
         d_req_valid = dv; d_req_addr = da; d_req_we = dwe; d_req_wdata = dw;
         #4;
         ni = 0; nd = 0; evi = 0; evd = 0; eidata = '0; eddata = '0;
         foreach (q[k]) begin
            if (q[k].port) nd++; else ni++;
            if (q[k].due == c) begin
               if (q[k].port) begin evd = 1; eddata = q[k].data; end
               else begin evi = 1; eidata = q[k].data; end
            end
         end
         ei = iv && (ni < 4);
         ed = dv && (nd < 4);
         gi = ei && (!ed || m_last);
         gd = ed && !gi;
         n_checks++;
         if ({i_req_ready, d_req_ready} !== {gi, gd})
            $display("FAIL rand_grant c%0d: got %b%b want %b%b", c, i_req_ready, d_req_ready, gi, gd);
         else n_pass++;
         n_checks++;
         if ({i_resp_valid, d_resp_valid} !== {evi, evd} ||
             i_resp_data !== eidata || d_resp_data !== eddata)
            $display("FAIL rand_resp c%0d: got %b%b %h %h want %b%b %h %h", c,
                     i_resp_valid, d_resp_valid, i_resp_data, d_resp_data, evi, evd, eidata, eddata);
         else n_pass++;
         n_checks++;
         if (mem_we !== (exp_issue && exp_we) || (exp_issue && mem_addr !== exp_addr) ||
             (exp_from_d && mem_wdata !== exp_wdata))
            $display("FAIL rand_issue c%0d: we %b addr %h wdata %h want %b %h %h", c,
                     mem_we, mem_addr, mem_wdata, exp_issue && exp_we, exp_addr, exp_wdata);
         else n_pass++;
         for (int k = q.size() - 1; k >= 0; k--) if (q[k].due <= c) q.delete(k);
         exp_issue = gi || gd; exp_from_d = gd; exp_we = gd && dwe;
         if (gi) begin
            q.push_back('{due: c + 5, port: 1'b0, we: 1'b0, data: memfn(ia)});
            m_last = 1'b0; iv = 0; exp_addr = ia;
         end
         if (gd) begin
            q.push_back('{due: c + 5, port: 1'b1, we: dwe, data: dwe ? 32'h0 : memfn(da)});
            m_last = 1'b1; dv = 0; exp_addr = da; exp_wdata = dw;
         end
         tick();
      end
      idle();
      repeat (7) tick();
   endtask

   initial begin
      rst_b = 1'b1;
      i_req_addr = '0; d_req_addr = '0; d_req_wdata = '0; lim_i_addr = '0;
      idle();
      test_reset();
      test_single_load();
      test_contention();
      test_out_limit();
      test_store();
      test_drain();
      test_reset_midflight();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
